cn_init_seq: RTL

Hardware loader/sequencer that initialises one or more `cn_top` channels without host software. For each enabled channel it:
- writes the 12 ML seed registers derived from a 12×64-bit h0 state;
- fills the scratchpad with the canonical counter pattern;
- issues start and waits for `ml_finished`.

It sits between the host control block and a bank of `NUM_CH` `cn_top` instances, driving their avalon reg/mem slave ports over shared buses with per-channel selects.

---
 rtl/cn_init_seq.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cn_init_seq.sv
// -----------------------------------------------------------------------------
// cn_init_seq
//
// Hardware loader/sequencer that brings up NUM_CH cn_top channels without host
// software. For every channel in the accepted mask it writes the 12 ML seed
// registers derived from that channel's 12x64-bit h0 state, fills the
// scratchpad with the counter pattern (lane i of word k = 8k+i), then issues a
// single START write to all masked channels and waits for each of them to
// report ml_finished.
//
// Build option:
//   CN_INIT_BCAST_FILL_EN  defined   : all REGS phases first, then one
//                                      scratchpad fill broadcast to the mask.
//                          undefined : REGS then MEM per channel, one-hot.
//
// Ports:
//   clk, reset_n       clock; asynchronous reset, asserted high
//   start, abort       begin a sequence (IDLE only) / return to IDLE at once
//   ch_mask            channels to process, latched on an accepted start
//   h0_in              per-channel h0, channel c word i at [768c+64i +: 64]
//   ml_finished        per-channel finished flags from cn_top
//   reg_*              register-port bus with per-channel select
//   mem_*              scratchpad-port bus with per-channel select
//   busy, done         high outside IDLE / one-cycle completion pulse
//   ch_done            sticky per-channel finished flags
// -----------------------------------------------------------------------------
module cn_init_seq #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int NUM_CH        = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*768-1:0]    h0_in,
  input  logic [NUM_CH-1:0]        ml_finished,
  output logic [NUM_CH-1:0]        reg_sel,
  output logic [7:0]               reg_address,
  output logic                     reg_write,
  output logic [31:0]              reg_wrdata,
  output logic [NUM_CH-1:0]        mem_sel,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write,
  output logic [511:0]             mem_wrdata,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        ch_done
);

  // One counter serves both the register index (0..11) and the fill word index.
  localparam int CW  = (ADDRESS_WIDTH > 4) ? ADDRESS_WIDTH : 4;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] REG_LAST = CW'(11);
  localparam logic [CW-1:0] MEM_LAST = CW'((1 << ADDRESS_WIDTH) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REGS  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] fin_q, fin_prev_q;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [NUM_CH-1:0] rise;
  logic [CHW:0]      first_ch, next_ch;

  logic [NUM_CH-1:0]        reg_sel_q, reg_sel_d;
  logic [7:0]               reg_address_q, reg_address_d;
  logic                     reg_write_q, reg_write_d;
  logic [31:0]              reg_wrdata_q, reg_wrdata_d;
  logic [NUM_CH-1:0]        mem_sel_q, mem_sel_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                     mem_write_q, mem_write_d;
  logic [511:0]             mem_wrdata_q, mem_wrdata_d;
  logic                     busy_q, busy_d, done_q, done_d;

  logic [767:0]      h0_ch;
  logic [511:0]      seed_words;
  logic [NUM_CH-1:0] ch_onehot;

  // Lowest masked channel with index >= from; MSB flags that one exists.
  function automatic logic [CHW:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
    logic [CHW:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= from && m[i]) r = {1'b1, CHW'(i)};
    end
    return r;
  endfunction

  assign first_ch = find_ch(ch_mask, 0);
  assign next_ch  = find_ch(mask_q, int'(ch_q) + 1);
  // Edge detect on the registered copy so ml_finished is sampled exactly once.
  assign rise     = fin_q & ~fin_prev_q & mask_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    ch_done_d = ch_done_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_d    = ch_mask;
            ch_done_d = '0;
            cnt_d     = '0;
            if (first_ch[CHW]) begin
              state_d = S_REGS;
              ch_d    = first_ch[CHW-1:0];
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_REGS: begin
          if (cnt_q == REG_LAST) begin
            cnt_d = '0;
`ifdef CN_INIT_BCAST_FILL_EN
            if (next_ch[CHW]) ch_d = next_ch[CHW-1:0];
            else              state_d = S_MEM;
`else
            state_d = S_MEM;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_MEM: begin
          if (cnt_q == MEM_LAST) begin
            cnt_d = '0;
`ifdef CN_INIT_BCAST_FILL_EN
            state_d = S_START;
`else
            if (next_ch[CHW]) begin
              state_d = S_REGS;
              ch_d    = next_ch[CHW-1:0];
            end else begin
              state_d = S_START;
            end
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_START: begin
          ch_done_d = ch_done_q | rise;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          ch_done_d = ch_done_q | rise;
          if ((ch_done_d & mask_q) == mask_q) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the *next* state, so every bus value is a flop output
  // and the first write appears the cycle after start is sampled.
  // ---------------------------------------------------------------------------
  always_comb begin
    h0_ch      = h0_in[int'(ch_d)*768 +: 768];
    // Register image, reg r = seed_words[32r +: 32]; upper words pad to 512.
    seed_words = {128'd0,
                  h0_ch[9*64 +: 64] ^ h0_ch[11*64 +: 64], h0_ch[8*64 +: 64] ^ h0_ch[10*64 +: 64],
                  h0_ch[3*64 +: 64] ^ h0_ch[7*64 +: 64],  h0_ch[2*64 +: 64] ^ h0_ch[6*64 +: 64],
                  h0_ch[1*64 +: 64] ^ h0_ch[5*64 +: 64],  h0_ch[0*64 +: 64] ^ h0_ch[4*64 +: 64]};
    ch_onehot       = '0;
    ch_onehot[ch_d] = 1'b1;

    reg_sel_d     = '0;
    reg_address_d = '0;
    reg_write_d   = 1'b0;
    reg_wrdata_d  = '0;
    mem_sel_d     = '0;
    mem_address_d = '0;
    mem_write_d   = 1'b0;
    mem_wrdata_d  = '0;
    case (state_d)
      S_REGS: begin
        reg_sel_d     = ch_onehot;
        reg_address_d = {4'd0, cnt_d[3:0]};
        reg_write_d   = 1'b1;
        reg_wrdata_d  = seed_words[32*cnt_d[3:0] +: 32];
      end
      S_MEM: begin
`ifdef CN_INIT_BCAST_FILL_EN
        mem_sel_d = mask_d;
`else
        mem_sel_d = ch_onehot;
`endif
        mem_address_d = cnt_d[ADDRESS_WIDTH-1:0];
        mem_write_d   = 1'b1;
        for (int i = 0; i < 8; i++) begin
          mem_wrdata_d[64*i +: 64] = 64'(cnt_d[ADDRESS_WIDTH-1:0]) * 64'd8 + 64'(i);
        end
      end
      S_START: begin
        reg_sel_d     = mask_d;
        reg_address_d = 8'd12;
        reg_write_d   = 1'b1;
        reg_wrdata_d  = 32'd1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so all flops update
  // together. reset_n is asserted high in this codebase despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ch_q          <= '0;
      mask_q        <= '0;
      fin_q         <= '0;
      fin_prev_q    <= '0;
      ch_done_q     <= '0;
      reg_sel_q     <= '0;
      reg_address_q <= '0;
      reg_write_q   <= 1'b0;
      reg_wrdata_q  <= '0;
      mem_sel_q     <= '0;
      mem_address_q <= '0;
      mem_write_q   <= 1'b0;
      mem_wrdata_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      mask_q        <= mask_d;
      fin_q         <= ml_finished;
      fin_prev_q    <= fin_q;
      ch_done_q     <= ch_done_d;
      reg_sel_q     <= reg_sel_d;
      reg_address_q <= reg_address_d;
      reg_write_q   <= reg_write_d;
      reg_wrdata_q  <= reg_wrdata_d;
      mem_sel_q     <= mem_sel_d;
      mem_address_q <= mem_address_d;
      mem_write_q   <= mem_write_d;
      mem_wrdata_q  <= mem_wrdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign reg_sel     = reg_sel_q;
  assign reg_address = reg_address_q;
  assign reg_write   = reg_write_q;
  assign reg_wrdata  = reg_wrdata_q;
  assign mem_sel     = mem_sel_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_wrdata  = mem_wrdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ch_done     = ch_done_q;

endmodule
